// File: rtl/eq2_run_detector_if.sv
// ---------------------------------------------------------------------------
// eq2_run_detector_if
// Stream bundle for the eq2 run detector: the operand-pair input stream and
// the run-length event output stream, each with its own valid/ready pair.
//
// Signals
//   in_valid     producer -> stage   input pair valid
//   in_ready     stage -> producer   stage can accept a pair
//   in_a, in_b   producer -> stage   2-bit operands
//   in_last      producer -> stage   final pair of a stream
//   out_valid    stage -> consumer   run event pending
//   out_ready    consumer -> stage   consumer accepts event
//   out_run_len  stage -> consumer   length of the terminated run (CW bits)
//
// Modports
//   master : the environment (drives the input stream and out_ready)
//   slave  : the detector itself
// ---------------------------------------------------------------------------
interface eq2_run_detector_if #(
   parameter int CW = 8
) ();

   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_a;
   logic [1:0]    in_b;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_run_len;

   modport master (
      output in_valid,
      output in_a,
      output in_b,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_run_len
   );

   modport slave (
      input  in_valid,
      input  in_a,
      input  in_b,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_run_len
   );

endinterface

// File: rtl/eq2_run_detector.sv
// ---------------------------------------------------------------------------
// eq2_run_detector
// Streaming stage placed directly after a 2-bit equality comparator. Each
// accepted operand pair is compared by an internal eq2 instance. Runs of
// consecutive equal pairs are counted; when a run of at least MIN_RUN pairs
// ends (by a mismatch or by an in_last beat) its length is offered as a
// single-slot event on the output stream. Saturating totals of equal and
// unequal accepted pairs are kept for status readout.
//
// Parameters
//   CW       width of run counter, event payload and totals (saturate at 2^CW-1)
//   MIN_RUN  minimum run length that produces an event (1 .. 2^CW-1)
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   clear     synchronous clear of run state, pending event and totals
//   bus       input pair stream + run event stream (slave side)
//   eq_total  saturating count of accepted equal pairs
//   ne_total  saturating count of accepted unequal pairs
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// eq2: 2-bit equality comparator (a, b -> aeqb), purely combinational.
// ---------------------------------------------------------------------------
module eq2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       aeqb
);

   // Both bit positions must agree.
   assign aeqb = (~(a[1] ^ b[1])) & (~(a[0] ^ b[0]));

endmodule

module eq2_run_detector #(
   parameter int CW      = 8,
   parameter int MIN_RUN = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   eq2_run_detector_if.slave     bus,
   output logic [CW-1:0]         eq_total,
   output logic [CW-1:0]         ne_total
);

   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] MIN_RUN_C = CW'(MIN_RUN);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Registered state and outputs
   state_t        state_r;
   logic [CW-1:0] run_cnt_r;
   logic          out_valid_r;
   logic [CW-1:0] out_run_len_r;
   logic [CW-1:0] eq_total_r;
   logic [CW-1:0] ne_total_r;

   // Combinational helpers
   logic          aeqb_s;
   logic          in_ready_s;
   logic          accept_s;
   logic          pop_s;
   logic [CW-1:0] run_inc_s;
   logic          emit_s;
   logic [CW-1:0] emit_len_s;

   // Saturating increment shared by the run counter and both totals.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      if (v == CNT_MAX) begin
         r = CNT_MAX;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   eq2 u_eq2 (
      .a    (bus.in_a),
      .b    (bus.in_b),
      .aeqb (aeqb_s)
   );

   // Handshake decode: single event slot, so input is blocked only while an
   // event is pending and the consumer is not taking it this cycle.
   always_comb begin
      in_ready_s = (~out_valid_r) | bus.out_ready;
      accept_s   = bus.in_valid & in_ready_s;
      pop_s      = out_valid_r & bus.out_ready;
      run_inc_s  = sat_inc(run_cnt_r);
   end

   // Event decision for the beat being accepted this cycle. An equal beat
   // only emits when it is the last of a stream (the run including it is
   // reported); an unequal beat emits the run that preceded it.
   always_comb begin
      emit_s     = 1'b0;
      emit_len_s = {CW{1'b0}};
      if (accept_s) begin
         if (aeqb_s) begin
            if (bus.in_last && (run_inc_s >= MIN_RUN_C)) begin
               emit_s     = 1'b1;
               emit_len_s = run_inc_s;
            end else begin
               emit_s     = 1'b0;
               emit_len_s = {CW{1'b0}};
            end
         end else begin
            if ((state_r == RUN) && (run_cnt_r >= MIN_RUN_C)) begin
               emit_s     = 1'b1;
               emit_len_s = run_cnt_r;
            end else begin
               emit_s     = 1'b0;
               emit_len_s = {CW{1'b0}};
            end
         end
      end else begin
         emit_s     = 1'b0;
         emit_len_s = {CW{1'b0}};
      end
   end

   // Run FSM, event slot and totals. clear outranks any accepted beat, which
   // is then consumed without effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         run_cnt_r     <= {CW{1'b0}};
         out_valid_r   <= 1'b0;
         out_run_len_r <= {CW{1'b0}};
         eq_total_r    <= {CW{1'b0}};
         ne_total_r    <= {CW{1'b0}};
      end else if (clear) begin
         state_r       <= IDLE;
         run_cnt_r     <= {CW{1'b0}};
         out_valid_r   <= 1'b0;
         out_run_len_r <= {CW{1'b0}};
         eq_total_r    <= {CW{1'b0}};
         ne_total_r    <= {CW{1'b0}};
      end else begin
         // A new event overwrites a slot being popped in the same cycle.
         if (emit_s) begin
            out_valid_r   <= 1'b1;
            out_run_len_r <= emit_len_s;
         end else if (pop_s) begin
            out_valid_r   <= 1'b0;
         end else begin
            out_valid_r   <= out_valid_r;
         end

         if (accept_s) begin
            case (state_r)
               IDLE: begin
                  if (aeqb_s && !bus.in_last) begin
                     state_r   <= RUN;
                     run_cnt_r <= CNT_ONE;
                  end else begin
                     state_r   <= IDLE;
                     run_cnt_r <= {CW{1'b0}};
                  end
               end
               RUN: begin
                  if (aeqb_s && !bus.in_last) begin
                     state_r   <= RUN;
                     run_cnt_r <= run_inc_s;
                  end else begin
                     state_r   <= IDLE;
                     run_cnt_r <= {CW{1'b0}};
                  end
               end
               default: begin
                  state_r   <= IDLE;
                  run_cnt_r <= {CW{1'b0}};
               end
            endcase

            if (aeqb_s) begin
               eq_total_r <= sat_inc(eq_total_r);
            end else begin
               ne_total_r <= sat_inc(ne_total_r);
            end
         end
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_run_len = out_run_len_r;
   assign eq_total        = eq_total_r;
   assign ne_total        = ne_total_r;

endmodule
